// File: rtl/cv32e40p_sleep_ctrl_if.sv
// cv32e40p_sleep_ctrl_if: sleep-controller signal bundle between the core, the clock gate and the controller
//   master: core/system side; drives the sleep, busy, wake and scan inputs and observes the results
//   slave : the controller; observes the inputs, drives clk_en_o, core_sleeping_o, wake_ack_o
//           (and sleep_cycles_o when CV32E40P_SLEEP_STATS_EN is defined)
interface cv32e40p_sleep_ctrl_if;
    logic        scan_cg_en_i;
    logic        sleep_req_i;
    logic        core_busy_i;
    logic        irq_pending_i;
    logic        debug_req_i;
    logic        wake_i;
    logic        clk_en_o;
    logic        core_sleeping_o;
    logic        wake_ack_o;
`ifdef CV32E40P_SLEEP_STATS_EN
    logic [31:0] sleep_cycles_o;
    modport master (
        output scan_cg_en_i, sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, wake_i,
        input  clk_en_o, core_sleeping_o, wake_ack_o, sleep_cycles_o
    );
    modport slave (
        input  scan_cg_en_i, sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, wake_i,
        output clk_en_o, core_sleeping_o, wake_ack_o, sleep_cycles_o
    );
`else
    modport master (
        output scan_cg_en_i, sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, wake_i,
        input  clk_en_o, core_sleeping_o, wake_ack_o
    );
    modport slave (
        input  scan_cg_en_i, sleep_req_i, core_busy_i, irq_pending_i, debug_req_i, wake_i,
        output clk_en_o, core_sleeping_o, wake_ack_o
    );
`endif
endinterface

// File: rtl/cv32e40p_sleep_ctrl.sv
// cv32e40p_sleep_ctrl: clock-enable generator for cv32e40p_clock_gate with idle qualification and wake settling
//   clk_i, rst_i : free-running clock, asynchronous active-high reset
//   bus (slave)  : sleep_req/core_busy/irq_pending/debug_req/wake/scan_cg_en in,
//                  clk_en_o/core_sleeping_o/wake_ack_o out
//   CV32E40P_SLEEP_STATS_EN : adds the saturating sleep_cycles_o counter
module cv32e40p_sleep_ctrl #(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cv32e40p_sleep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

    state_t     state;
    logic [7:0] idle_cnt;
    logic [7:0] wake_cnt;
    logic       wake_ack;
    logic       wake_any;
    logic       qual;

    assign wake_any = bus.irq_pending_i | bus.debug_req_i | bus.wake_i;
    assign qual     = bus.sleep_req_i & ~bus.core_busy_i & ~wake_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= RUN;
            idle_cnt <= '0;
            wake_cnt <= '0;
            wake_ack <= 1'b0;
        end else begin
            wake_ack <= 1'b0;
            case (state)
                RUN: if (qual) begin
                    state    <= (IDLE_CYCLES == 1) ? SLEEP : DRAIN;
                    idle_cnt <= (IDLE_CYCLES == 1) ? 8'd0 : 8'd1;
                end
                DRAIN: if (!qual) begin
                    state    <= RUN;
                    idle_cnt <= '0;
                end else if (idle_cnt == IDLE_LAST) begin
                    state    <= SLEEP;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 8'd1;
                end
                SLEEP: if (wake_any) begin
                    state    <= WAKE;
                    wake_cnt <= '0;
                end
                WAKE: if (wake_cnt == WAKE_LAST) begin
                    state    <= RUN;
                    wake_cnt <= '0;
                    wake_ack <= 1'b1;
                end else begin
                    wake_cnt <= wake_cnt + 8'd1;
                end
                default: state <= RUN;
            endcase
        end
    end

    // decoded from registered state only, so the latch gate sees no glitches
    assign bus.clk_en_o        = (state != SLEEP) | bus.scan_cg_en_i;
    assign bus.core_sleeping_o = (state == SLEEP) | (state == WAKE);
    assign bus.wake_ack_o      = wake_ack;

`ifdef CV32E40P_SLEEP_STATS_EN
    logic [31:0] sleep_cnt;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sleep_cnt <= '0;
        else if (state == SLEEP && sleep_cnt != '1) sleep_cnt <= sleep_cnt + 32'd1;
    end
    assign bus.sleep_cycles_o = sleep_cnt;
`endif
endmodule
